// File: rtl/detect_winner_scan.sv
// Sequential N-in-a-row winner detector.
// A start pulse snapshots the board; one anchor cell is examined per cycle,
// checking four line directions from it. The first line found (lowest anchor,
// then lowest direction) ends the scan; otherwise the full board is classified
// as tie or still playing. Results are registered and held until the next scan.
module detect_winner_scan #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIN_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ROWS*COLS-1:0]       game_board,
    input  logic [ROWS*COLS-1:0]       player_cells,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 game_status,
    output logic [$clog2(ROWS)-1:0]    win_row,
    output logic [$clog2(COLS)-1:0]    win_col,
    output logic [1:0]                 win_dir
);

    localparam int N    = ROWS * COLS;
    localparam int IDXW = $clog2(N);
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx;

    logic [N-1:0]      board_r;
    logic [N-1:0]      player_r;
    logic [IDXW-1:0]   idx_r;
    logic [RW-1:0]     row_r;
    logic [CW-1:0]     col_r;

    logic              busy_r;
    logic              done_r;
    logic [1:0]        status_r;
    logic [RW-1:0]     win_row_r;
    logic [CW-1:0]     win_col_r;
    logic [1:0]        win_dir_r;

    logic [3:0]        dir_match_s;
    logic              found_s;
    logic [1:0]        found_dir_s;
    logic              owner_s;
    logic              last_anchor_s;
    logic              line_ok_s;
    int                cell_row_s;
    int                cell_col_s;
    logic [IDXW-1:0]   cell_idx_s;

    // Row step of direction d: only +col (d=0) stays on the same row.
    function automatic int step_row(input int d);
        int s;
        case (d)
            0:       s = 0;
            1:       s = 1;
            2:       s = 1;
            3:       s = 1;
            default: s = 0;
        endcase
        return s;
    endfunction

    // Column step of direction d: +col, none, +col, -col.
    function automatic int step_col(input int d);
        int s;
        case (d)
            0:       s = 1;
            1:       s = 0;
            2:       s = 1;
            3:       s = -1;
            default: s = 0;
        endcase
        return s;
    endfunction

    assign owner_s       = player_r[idx_r];
    assign last_anchor_s = (idx_r == IDXW'(N - 1));

    // Check the four lines starting at the current anchor against the snapshot.
    always_comb begin
        dir_match_s = 4'b0000;
        line_ok_s   = 1'b0;
        cell_row_s  = 0;
        cell_col_s  = 0;
        cell_idx_s  = '0;
        for (int d = 0; d < 4; d++) begin
            line_ok_s = 1'b1;
            for (int k = 0; k < WIN_LEN; k++) begin
                cell_row_s = int'(row_r) + k * step_row(d);
                cell_col_s = int'(col_r) + k * step_col(d);
                if (cell_row_s < 0 || cell_row_s >= ROWS ||
                    cell_col_s < 0 || cell_col_s >= COLS) begin
                    // Off the board: lines never wrap into the next row.
                    line_ok_s = 1'b0;
                end else begin
                    cell_idx_s = IDXW'(cell_row_s * COLS + cell_col_s);
                    if (!board_r[cell_idx_s] || (player_r[cell_idx_s] != owner_s)) begin
                        line_ok_s = 1'b0;
                    end else begin
                        line_ok_s = line_ok_s;
                    end
                end
            end
            dir_match_s[d] = line_ok_s;
        end
    end

    // Pick the lowest-numbered matching direction.
    always_comb begin
        found_s     = 1'b0;
        found_dir_s = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (dir_match_s[d]) begin
                found_s     = 1'b1;
                found_dir_s = 2'(d);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Next-state logic: IDLE -> SCAN -> DONE -> IDLE.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                end else begin
                    state_nx = IDLE;
                end
            end
            SCAN: begin
                if (found_s || last_anchor_s) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SCAN;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Snapshot, anchor walk and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_r   <= '0;
            player_r  <= '0;
            idx_r     <= '0;
            row_r     <= '0;
            col_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            status_r  <= 2'b00;
            win_row_r <= '0;
            win_col_r <= '0;
            win_dir_r <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        board_r  <= game_board;
                        player_r <= player_cells;
                        idx_r    <= '0;
                        row_r    <= '0;
                        col_r    <= '0;
                    end else begin
                        idx_r    <= idx_r;
                    end
                end
                SCAN: begin
                    if (found_s) begin
                        status_r  <= owner_s ? 2'b10 : 2'b01;
                        win_row_r <= row_r;
                        win_col_r <= col_r;
                        win_dir_r <= found_dir_s;
                    end else if (last_anchor_s) begin
                        // A full board with no line is a tie.
                        status_r  <= (&board_r) ? 2'b11 : 2'b00;
                        win_row_r <= '0;
                        win_col_r <= '0;
                        win_dir_r <= 2'd0;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                        if (col_r == CW'(COLS - 1)) begin
                            col_r <= '0;
                            row_r <= row_r + RW'(1);
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
            busy_r <= (state_nx != IDLE);
            done_r <= (state_nx == DONE);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign game_status = status_r;
    assign win_row     = win_row_r;
    assign win_col     = win_col_r;
    assign win_dir     = win_dir_r;

endmodule

// File: tb/tb_detect_winner_scan.sv
// Bench for detect_winner_scan: directed boards plus randomized boards on a
// 4x4 instance, and a 6x7 instance, all checked against a reference model
// that walks the board by plain row/column arithmetic.
module tb_detect_winner_scan;

    logic        clk;
    logic        reset;

    logic        start;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic        busy;
    logic        done;
    logic [1:0]  game_status;
    logic [1:0]  win_row;
    logic [1:0]  win_col;
    logic [1:0]  win_dir;

    logic        start7;
    logic [41:0] board7;
    logic [41:0] player7;
    logic        busy7;
    logic        done7;
    logic [1:0]  status7;
    logic [2:0]  row7;
    logic [2:0]  col7;
    logic [1:0]  dir7;

    int n_cmp;
    int n_err;

    detect_winner_scan #(.ROWS(4), .COLS(4), .WIN_LEN(4)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .game_board(game_board), .player_cells(player_cells),
        .busy(busy), .done(done), .game_status(game_status),
        .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
    );

    detect_winner_scan #(.ROWS(6), .COLS(7), .WIN_LEN(4)) u_dut7 (
        .clk(clk), .reset(reset), .start(start7),
        .game_board(board7), .player_cells(player7),
        .busy(busy7), .done(done7), .game_status(status7),
        .win_row(row7), .win_col(col7), .win_dir(dir7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: try every anchor in order, every direction, every cell of the line.
    task automatic ref_model(input logic [63:0] b, input logic [63:0] p,
                             input int rows, input int cols, input int wl,
                             output int st, output int wr, output int wc,
                             output int wd, output int lat);
        int  drs[4];
        int  dcs[4];
        bit  found;
        bit  ok;
        bit  full;
        int  rr;
        int  cc;
        drs = '{0, 1, 1, 1};
        dcs = '{1, 0, 1, -1};
        found = 1'b0;
        st = 0; wr = 0; wc = 0; wd = 0;
        lat = rows * cols + 1;
        for (int a = 0; a < rows * cols && !found; a++) begin
            for (int d = 0; d < 4 && !found; d++) begin
                ok = 1'b1;
                for (int k = 0; k < wl; k++) begin
                    rr = a / cols + k * drs[d];
                    cc = a % cols + k * dcs[d];
                    if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) ok = 1'b0;
                    else if (!b[rr * cols + cc] || p[rr * cols + cc] != p[a]) ok = 1'b0;
                end
                if (ok) begin
                    found = 1'b1;
                    st  = p[a] ? 2 : 1;
                    wr  = a / cols;
                    wc  = a % cols;
                    wd  = d;
                    lat = a + 2;
                end
            end
        end
        if (!found) begin
            full = 1'b1;
            for (int i = 0; i < rows * cols; i++) if (!b[i]) full = 1'b0;
            st = full ? 3 : 0;
        end
    endtask

    task automatic run4(input string tag, input logic [15:0] b, input logic [15:0] p);
        int st, wr, wc, wd, lat, seen;
        bit got;
        ref_model({48'd0, b}, {48'd0, p}, 4, 4, 4, st, wr, wc, wd, lat);
        @(negedge clk);
        game_board = b; player_cells = p; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        game_board = 16'($urandom);
        player_cells = 16'($urandom);
        got = 1'b0; seen = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, ".busy_scan"}, 32'(busy), 32'd1);
            if (done) begin got = 1'b1; seen = c; end
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(seen), 32'(lat));
        check({tag, ".status"}, 32'(game_status), 32'(st));
        check({tag, ".row"}, 32'(win_row), 32'(wr));
        check({tag, ".col"}, 32'(win_col), 32'(wc));
        check({tag, ".dir"}, 32'(win_dir), 32'(wd));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check({tag, ".status_hold"}, 32'(game_status), 32'(st));
    endtask

    task automatic run7(input string tag, input logic [41:0] b, input logic [41:0] p);
        int st, wr, wc, wd, lat, seen;
        bit got;
        logic [63:0] r64;
        ref_model({22'd0, b}, {22'd0, p}, 6, 7, 4, st, wr, wc, wd, lat);
        @(negedge clk);
        board7 = b; player7 = p; start7 = 1'b1;
        @(posedge clk);
        #1;
        start7 = 1'b0;
        r64 = {$urandom, $urandom};
        board7 = r64[41:0];
        r64 = {$urandom, $urandom};
        player7 = r64[41:0];
        got = 1'b0; seen = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, ".busy_scan"}, 32'(busy7), 32'd1);
            if (done7) begin got = 1'b1; seen = c; end
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(seen), 32'(lat));
        check({tag, ".status"}, 32'(status7), 32'(st));
        check({tag, ".row"}, 32'(row7), 32'(wr));
        check({tag, ".col"}, 32'(col7), 32'(wc));
        check({tag, ".dir"}, 32'(dir7), 32'(wd));
    endtask

    initial begin
        logic [15:0] b;
        logic [15:0] p;
        logic [15:0] mask;
        logic [63:0] r64;
        logic [41:0] b7;
        logic [41:0] p7;
        int          sel;
        int          ndone;

        n_cmp = 0; n_err = 0;
        clk = 1'b0; reset = 1'b1;
        start = 1'b0; game_board = 16'd0; player_cells = 16'd0;
        start7 = 1'b0; board7 = 42'd0; player7 = 42'd0;

        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.status", 32'(game_status), 32'd0);
        check("rst.win", 32'({win_row, win_col, win_dir}), 32'd0);
        check("rst7.status", 32'({busy7, done7, status7}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed boards.
        run4("t1_row0", 16'h000F, 16'h0000);
        run4("t2_col3_p2", 16'h8888, 16'h8888);
        run4("t3_antidiag", 16'h1248, 16'h0000);
        run4("t4_col3_p1", 16'h8888, 16'h0000);
        run4("t5_tie", 16'hFFFF, 16'hC3C3);
        run4("t5_empty", 16'h0000, 16'h0000);
        run4("diag_p2", 16'h8421, 16'h8421);
        run4("top_row_p2", 16'hF000, 16'hF000);

        // Randomized boards, biased toward containing lines.
        for (int i = 0; i < 60; i++) begin
            b = 16'($urandom);
            p = 16'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                mask = 16'h000F << (4 * $urandom_range(0, 3));
                b = b | mask;
                p = ($urandom_range(0, 1) == 1) ? (p | mask) : (p & ~mask);
            end else if (sel == 1) begin
                mask = 16'h1111 << $urandom_range(0, 3);
                b = b | mask;
                p = ($urandom_range(0, 1) == 1) ? (p | mask) : (p & ~mask);
            end else if (sel == 2) begin
                b = b & 16'($urandom);
            end else begin
                b = 16'hFFFF;
            end
            run4("rand4", b, p);
        end

        // start during SCAN is ignored: exactly one done for one launch.
        @(negedge clk);
        game_board = 16'hFFFF; player_cells = 16'hC3C3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (done) ndone++;
        end
        check("t6_one_done", 32'(ndone), 32'd1);
        check("t6_status", 32'(game_status), 32'd3);

        // Reset in cycle 5 of a scan aborts at once.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_status", 32'(game_status), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6_no_done_after_rst", 32'(ndone), 32'd0);

        // 6x7 board, 4 in a row.
        b7 = 42'd0; p7 = 42'd0;
        for (int c = 3; c <= 6; c++) begin b7[c] = 1'b1; p7[c] = 1'b1; end
        run7("t7_p2_row0", b7, p7);
        b7 = 42'd0; p7 = 42'd0;
        b7[5] = 1'b1; b7[6] = 1'b1; b7[7] = 1'b1; b7[8] = 1'b1;
        run7("t7_no_wrap", b7, p7);
        for (int i = 0; i < 8; i++) begin
            r64 = {$urandom, $urandom};
            b7 = r64[41:0];
            r64 = {$urandom, $urandom};
            p7 = r64[41:0];
            run7("rand7", b7, p7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
